// File: rtl/dcache_wb.sv
// Direct-mapped write-back data cache between the core load/store port and BurstRAM.
// A miss first writes back a dirty victim, then refills the whole line and replays the request.
module dcache_wb #(
    parameter int ADDRESS_BITWIDTH         = 32,
    parameter int DATA_BITWIDTH            = 32,
    parameter int LINE_IX_BITWIDTH         = 4,
    parameter int DATA_IX_IN_LINE_BITWIDTH = 3,
    parameter int RAM_BURST_DATA_COUNT     = 4,
    parameter int RAM_BURST_DATA_BITWIDTH  = 64,
    parameter int RAM_DEPTH_BITWIDTH       = 4
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 enable,
    input  logic [ADDRESS_BITWIDTH-1:0]          address,
    input  logic [DATA_BITWIDTH/8-1:0]           write_enable,
    input  logic [DATA_BITWIDTH-1:0]             data_in,
    output logic [DATA_BITWIDTH-1:0]             data_out,
    output logic                                 data_ready,
    output logic                                 busy,
    output logic                                 br_cmd,
    output logic                                 br_cmd_en,
    output logic [RAM_DEPTH_BITWIDTH-1:0]        br_addr,
    output logic [RAM_BURST_DATA_BITWIDTH-1:0]   br_wr_data,
    output logic [RAM_BURST_DATA_BITWIDTH/8-1:0] br_data_mask,
    input  logic [RAM_BURST_DATA_BITWIDTH-1:0]   br_rd_data,
    input  logic                                 br_rd_data_valid,
    input  logic                                 br_busy
);
    localparam int LINES             = 1 << LINE_IX_BITWIDTH;
    localparam int WORDS             = 1 << DATA_IX_IN_LINE_BITWIDTH;
    localparam int BYTES             = DATA_BITWIDTH / 8;
    localparam int OFFSET_BITS       = $clog2(BYTES);
    localparam int TAG_BITWIDTH      = ADDRESS_BITWIDTH - LINE_IX_BITWIDTH - DATA_IX_IN_LINE_BITWIDTH - OFFSET_BITS;
    localparam int DATA_PER_RAM_DATA = RAM_BURST_DATA_BITWIDTH / DATA_BITWIDTH;
    localparam int BEAT_SHIFT        = $clog2(RAM_BURST_DATA_BITWIDTH / 8);
    localparam int BURST_IX_BITWIDTH = (RAM_BURST_DATA_COUNT > 1) ? $clog2(RAM_BURST_DATA_COUNT) : 1;
    localparam int LOW_BITS          = DATA_IX_IN_LINE_BITWIDTH + OFFSET_BITS;

    typedef enum logic [2:0] {IDLE, WB_ISSUE, WB_BEATS, RD_ISSUE, RD_WAIT, COMPLETE} state_t;
    state_t state, next_state;

    logic [LINES-1:0]              valid, dirty;
    logic [TAG_BITWIDTH-1:0]       tags  [LINES];
    logic [DATA_BITWIDTH-1:0]      words [LINES*WORDS];
    logic [ADDRESS_BITWIDTH-1:0]   req_address;
    logic [BYTES-1:0]              req_write_enable;
    logic [DATA_BITWIDTH-1:0]      req_data;
    logic [BURST_IX_BITWIDTH-1:0]  burst_ix;
    logic [63:0]                   hits, misses, writebacks;

    logic [ADDRESS_BITWIDTH-1:0]        acc_address, victim_beat_addr, fill_beat_addr;
    logic [BYTES-1:0]                   acc_write_enable;
    logic [DATA_BITWIDTH-1:0]           acc_data, acc_word, merged_word;
    logic [TAG_BITWIDTH-1:0]            acc_tag, req_tag;
    logic [LINE_IX_BITWIDTH-1:0]        acc_line, req_line;
    logic [DATA_IX_IN_LINE_BITWIDTH-1:0] acc_word_ix;
    logic [RAM_BURST_DATA_BITWIDTH-1:0] victim_beat;
    logic [BURST_IX_BITWIDTH-1:0]       victim_beat_ix;
    logic hit, do_access, do_miss, issue_wb, wb_beat, wb_last, issue_rd, fill_beat, fill_last;
    logic unused_bits;

    // A completing miss replays the latched request through the same path a hit uses.
    always_comb begin
        acc_address      = (state == COMPLETE) ? req_address : address;
        acc_write_enable = (state == COMPLETE) ? req_write_enable : write_enable;
        acc_data         = (state == COMPLETE) ? req_data : data_in;
        merged_word      = acc_word;
        for (int b = 0; b < BYTES; b++) begin
            if (acc_write_enable[b]) merged_word[b*8 +: 8] = acc_data[b*8 +: 8];
        end
    end

    assign acc_tag     = acc_address[ADDRESS_BITWIDTH-1 -: TAG_BITWIDTH];
    assign acc_line    = acc_address[LOW_BITS +: LINE_IX_BITWIDTH];
    assign acc_word_ix = acc_address[OFFSET_BITS +: DATA_IX_IN_LINE_BITWIDTH];
    assign acc_word    = words[{acc_line, acc_word_ix}];
    assign hit         = valid[acc_line] && (tags[acc_line] == acc_tag);
    assign req_tag     = req_address[ADDRESS_BITWIDTH-1 -: TAG_BITWIDTH];
    assign req_line    = req_address[LOW_BITS +: LINE_IX_BITWIDTH];

    assign victim_beat_addr = {tags[req_line], req_line, {LOW_BITS{1'b0}}} >> BEAT_SHIFT;
    assign fill_beat_addr   = {req_tag, req_line, {LOW_BITS{1'b0}}} >> BEAT_SHIFT;
    assign victim_beat_ix   = (state == WB_ISSUE) ? '0 : burst_ix;
    assign unused_bits      = ^{acc_address[OFFSET_BITS-1:0], victim_beat_addr, fill_beat_addr};

    always_comb begin
        victim_beat = '0;
        for (int k = 0; k < DATA_PER_RAM_DATA; k++) begin
            victim_beat[k*DATA_BITWIDTH +: DATA_BITWIDTH] =
                words[{req_line, DATA_IX_IN_LINE_BITWIDTH'(int'(victim_beat_ix) * DATA_PER_RAM_DATA + k)}];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:     if (do_miss) next_state = (valid[acc_line] && dirty[acc_line]) ? WB_ISSUE : RD_ISSUE;
            WB_ISSUE: if (!br_busy) next_state = WB_BEATS;
            WB_BEATS: if (wb_last) next_state = RD_ISSUE;
            RD_ISSUE: if (!br_busy) next_state = RD_WAIT;
            RD_WAIT:  if (fill_last) next_state = COMPLETE;
            COMPLETE: next_state = IDLE;
            default:  next_state = IDLE;
        endcase
    end

    always_comb begin
        do_access = 1'b0;
        do_miss   = 1'b0;
        issue_wb  = 1'b0;
        wb_beat   = 1'b0;
        wb_last   = 1'b0;
        issue_rd  = 1'b0;
        fill_beat = 1'b0;
        fill_last = 1'b0;
        case (state)
            IDLE: begin
                do_access = enable && hit;
                do_miss   = enable && !hit;
            end
            WB_ISSUE: issue_wb = !br_busy;
            WB_BEATS: begin
                wb_beat = 1'b1;
                wb_last = (burst_ix == BURST_IX_BITWIDTH'(RAM_BURST_DATA_COUNT - 1));
            end
            RD_ISSUE: issue_rd = !br_busy;
            RD_WAIT: begin
                fill_beat = br_rd_data_valid;
                fill_last = br_rd_data_valid && (burst_ix == BURST_IX_BITWIDTH'(RAM_BURST_DATA_COUNT - 1));
            end
            COMPLETE: do_access = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (fill_beat) begin
            for (int k = 0; k < DATA_PER_RAM_DATA; k++) begin
                words[{req_line, DATA_IX_IN_LINE_BITWIDTH'(int'(burst_ix) * DATA_PER_RAM_DATA + k)}] <=
                    br_rd_data[k*DATA_BITWIDTH +: DATA_BITWIDTH];
            end
        end else if (do_access && (|acc_write_enable)) begin
            words[{acc_line, acc_word_ix}] <= merged_word;
        end
    end

    // The line stays invalid from read issue until its last beat lands, so an abort never leaves stale data valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= '0; dirty <= '0;
            for (int i = 0; i < LINES; i++) tags[i] <= '0;
            req_address <= '0; req_write_enable <= '0; req_data <= '0; burst_ix <= '0;
            data_out <= '0; data_ready <= 1'b0; busy <= 1'b0;
            br_cmd <= 1'b0; br_cmd_en <= 1'b0; br_addr <= '0; br_wr_data <= '0; br_data_mask <= '0;
            hits <= '0; misses <= '0; writebacks <= '0;
        end else begin
            data_ready <= 1'b0;
            br_cmd_en  <= 1'b0;
            if (do_access) begin
                data_out   <= merged_word;
                data_ready <= 1'b1;
                busy       <= 1'b0;
                if (|acc_write_enable) dirty[acc_line] <= 1'b1;
                if (state == IDLE) hits <= hits + 64'd1;
            end
            if (do_miss) begin
                req_address      <= address;
                req_write_enable <= write_enable;
                req_data         <= data_in;
                busy             <= 1'b1;
                misses           <= misses + 64'd1;
            end
            if (issue_wb) begin
                br_cmd       <= 1'b1;
                br_cmd_en    <= 1'b1;
                br_data_mask <= '0;
                br_addr      <= victim_beat_addr[RAM_DEPTH_BITWIDTH-1:0];
                br_wr_data   <= victim_beat;
                burst_ix     <= BURST_IX_BITWIDTH'(1);
                writebacks   <= writebacks + 64'd1;
            end
            if (wb_beat) begin
                br_wr_data <= victim_beat;
                burst_ix   <= wb_last ? '0 : burst_ix + 1'b1;
                if (wb_last) dirty[req_line] <= 1'b0;
            end
            if (issue_rd) begin
                br_cmd          <= 1'b0;
                br_cmd_en       <= 1'b1;
                br_addr         <= fill_beat_addr[RAM_DEPTH_BITWIDTH-1:0];
                tags[req_line]  <= req_tag;
                valid[req_line] <= 1'b0;
                dirty[req_line] <= 1'b0;
                burst_ix        <= '0;
            end
            if (fill_beat) begin
                burst_ix <= fill_last ? '0 : burst_ix + 1'b1;
                if (fill_last) valid[req_line] <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_dcache_wb.sv
// Self-checking bench for dcache_wb: a behavioural BurstRAM and a flat-memory reference model
// that predicts load values, hit/miss and write-back traffic from the cache rules.
module tb_dcache_wb;
    localparam int RDB        = 8;
    localparam int RD_LATENCY = 2;
    localparam int WAIT_LIMIT = 200;

    logic           clk = 1'b0;
    logic           rst, enable, br_busy;
    logic [31:0]    address, data_in, data_out;
    logic [3:0]     write_enable;
    logic           data_ready, busy, br_cmd, br_cmd_en;
    logic [RDB-1:0] br_addr;
    logic [63:0]    br_wr_data;
    logic [7:0]     br_data_mask;
    logic [63:0]    br_rd_data = '0;
    logic           br_rd_data_valid = 1'b0;

    int checks = 0;
    int errors = 0;

    dcache_wb #(.RAM_DEPTH_BITWIDTH(RDB)) dut (
        .clk(clk), .rst(rst), .enable(enable), .address(address), .write_enable(write_enable),
        .data_in(data_in), .data_out(data_out), .data_ready(data_ready), .busy(busy),
        .br_cmd(br_cmd), .br_cmd_en(br_cmd_en), .br_addr(br_addr), .br_wr_data(br_wr_data),
        .br_data_mask(br_data_mask), .br_rd_data(br_rd_data), .br_rd_data_valid(br_rd_data_valid),
        .br_busy(br_busy)
    );

    always #5 clk = ~clk;

    // Behavioural BurstRAM: untouched words read back as their own byte address.
    logic [31:0]    ram_mem [int];
    int             n_rd = 0, n_wr = 0;
    logic [RDB-1:0] last_rd_addr = '0, last_wr_addr = '0;
    logic [63:0]    wr_beats [4];
    bit             mask_bad = 0;
    int rd_left = 0, rd_wait = 0, rd_beat = 0, rd_base = 0, cur_beat = 0;
    int wr_left = 0, wr_beat = 0, wr_base = 0;

    function automatic logic [31:0] ram_word(int a);
        return ram_mem.exists(a) ? ram_mem[a] : a;
    endfunction

    task automatic store_beat(input int ba, input logic [63:0] d);
        ram_mem[ba*8]     = d[31:0];
        ram_mem[ba*8 + 4] = d[63:32];
    endtask

    always @(negedge clk) begin
        br_rd_data_valid = 1'b0;
        if (rst) begin
            rd_left = 0;
            wr_left = 0;
        end else begin
            if (wr_left > 0) begin
                store_beat(wr_base + wr_beat, br_wr_data);
                wr_beats[wr_beat] = br_wr_data;
                if (br_data_mask != 0) mask_bad = 1;
                wr_beat++;
                wr_left--;
            end
            if (rd_left > 0) begin
                if (rd_wait > 0) rd_wait--;
                else begin
                    cur_beat = rd_beat;
                    br_rd_data = {ram_word((rd_base + rd_beat)*8 + 4), ram_word((rd_base + rd_beat)*8)};
                    br_rd_data_valid = 1'b1;
                    rd_beat++;
                    rd_left--;
                end
            end
            if (br_cmd_en) begin
                if (br_cmd) begin
                    n_wr++;
                    last_wr_addr = br_addr;
                    wr_base = int'(br_addr);
                    store_beat(wr_base, br_wr_data);
                    wr_beats[0] = br_wr_data;
                    if (br_data_mask != 0) mask_bad = 1;
                    wr_beat = 1;
                    wr_left = 3;
                end else begin
                    n_rd++;
                    last_rd_addr = br_addr;
                    rd_base = int'(br_addr);
                    rd_wait = RD_LATENCY;
                    rd_beat = 0;
                    rd_left = 4;
                end
            end
        end
    end

    // Reference model: a flat, always-coherent memory plus the tag/valid/dirty view of each line.
    logic [31:0] model_mem [int];
    bit          m_valid [16];
    bit          m_dirty [16];
    int          m_tag   [16];

    function automatic logic [31:0] model_read(int a);
        return model_mem.exists(a) ? model_mem[a] : a;
    endfunction

    task automatic model_access(input int a, input logic [3:0] we, input logic [31:0] din,
                                output logic [31:0] expected, output bit hit, output bit wb);
        int line;
        int tag;
        line = (a / 32) % 16;
        tag  = a / 512;
        expected = model_read(a);
        for (int b = 0; b < 4; b++) if (we[b]) expected[b*8 +: 8] = din[b*8 +: 8];
        hit = m_valid[line] && (m_tag[line] == tag);
        wb  = !hit && m_valid[line] && m_dirty[line];
        if (we != 0) model_mem[a] = expected;
        if (!hit) begin
            m_valid[line] = 1;
            m_tag[line]   = tag;
            m_dirty[line] = 0;
        end
        if (we != 0) m_dirty[line] = 1;
    endtask

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    task automatic issue(input int a, input logic [3:0] we, input logic [31:0] din);
        enable = 1'b1; address = a; write_enable = we; data_in = din;
        tick;
        enable = 1'b0; write_enable = 4'h0;
    endtask

    task automatic wait_ready(output int cycles, output bit timed_out, output bit busy_low);
        cycles = 0;
        busy_low = 0;
        while (data_ready !== 1'b1 && cycles < WAIT_LIMIT) begin
            if (busy !== 1'b1) busy_low = 1;
            tick;
            cycles++;
        end
        timed_out = (data_ready !== 1'b1);
    endtask

    task automatic test_reset;
        rst = 1'b1; enable = 1'b0; address = '0; write_enable = '0; data_in = '0; br_busy = 1'b0;
        repeat (3) tick;
        checks++; if (data_out !== 32'h0) begin errors++; $display("[TB] FAIL reset_data_out: got %h want 0", data_out); end
        checks++; if ({data_ready, busy, br_cmd, br_cmd_en} !== 4'b0) begin errors++; $display("[TB] FAIL reset_flags: got %b want 0000", {data_ready, busy, br_cmd, br_cmd_en}); end
        checks++; if ({br_addr, br_wr_data, br_data_mask} !== '0) begin errors++; $display("[TB] FAIL reset_bus: got addr %h data %h mask %h want 0", br_addr, br_wr_data, br_data_mask); end
        rst = 1'b0;
        tick;
        checks++; if (busy !== 1'b0 || br_cmd_en !== 1'b0) begin errors++; $display("[TB] FAIL reset_release: got busy %b cmd_en %b want 0 0", busy, br_cmd_en); end
    endtask

    task automatic test_cold_read;
        logic [31:0] expected; bit hit, wb, to, busy_low; int cyc, r0, w0;
        r0 = n_rd; w0 = n_wr;
        model_access(32'h104, 4'h0, 32'h0, expected, hit, wb);
        issue(32'h104, 4'h0, 32'h0);
        wait_ready(cyc, to, busy_low);
        checks++; if (to) begin errors++; $display("[TB] FAIL cold_timeout: got no data_ready want data_ready within %0d cycles", WAIT_LIMIT); end
        checks++; if (busy_low || cyc == 0) begin errors++; $display("[TB] FAIL cold_busy: got busy_low %0d after %0d cycles want busy held during fill", busy_low, cyc); end
        checks++; if (data_out !== expected) begin errors++; $display("[TB] FAIL cold_data: got %h want %h", data_out, expected); end
        checks++; if (n_rd - r0 != 1 || n_wr != w0 || last_rd_addr !== 8'h20) begin errors++; $display("[TB] FAIL cold_traffic: got rd %0d wr %0d addr %h want 1 0 20", n_rd - r0, n_wr - w0, last_rd_addr); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL cold_busy_drop: got %b want 0", busy); end
        tick;
        checks++; if (data_ready !== 1'b0) begin errors++; $display("[TB] FAIL cold_pulse: got %b want 0", data_ready); end
    endtask

    task automatic test_hits;
        logic [31:0] expected; bit hit, wb, to, busy_low; int cyc, r0, w0;
        logic [31:0] addrs [3] = '{32'h108, 32'h108, 32'h108};
        logic [3:0]  wes   [3] = '{4'h0, 4'h3, 4'h0};
        r0 = n_rd; w0 = n_wr;
        for (int i = 0; i < 3; i++) begin
            model_access(addrs[i], wes[i], 32'hAABBCCDD, expected, hit, wb);
            issue(addrs[i], wes[i], 32'hAABBCCDD);
            wait_ready(cyc, to, busy_low);
            checks++; if (cyc != 0 || to) begin errors++; $display("[TB] FAIL hit_latency_%0d: got %0d extra cycles want 0", i, cyc); end
            checks++; if (data_out !== expected) begin errors++; $display("[TB] FAIL hit_data_%0d: got %h want %h", i, data_out, expected); end
        end
        checks++; if (data_out !== 32'h0000CCDD) begin errors++; $display("[TB] FAIL hit_merge: got %h want 0000ccdd", data_out); end
        checks++; if (n_rd != r0 || n_wr != w0) begin errors++; $display("[TB] FAIL hit_traffic: got rd %0d wr %0d want 0 0", n_rd - r0, n_wr - w0); end
    endtask

    task automatic test_conflict_wb;
        logic [31:0] expected; bit hit, wb, to, busy_low; int cyc, r0, w0;
        r0 = n_rd; w0 = n_wr;
        model_access(32'h308, 4'h0, 32'h0, expected, hit, wb);
        issue(32'h308, 4'h0, 32'h0);
        wait_ready(cyc, to, busy_low);
        checks++; if (to || data_out !== 32'h308) begin errors++; $display("[TB] FAIL conflict_data: got %h timeout %0d want 00000308", data_out, to); end
        checks++; if (n_wr - w0 != 1 || last_wr_addr !== 8'h20 || mask_bad) begin errors++; $display("[TB] FAIL conflict_wb_cmd: got wr %0d addr %h mask_bad %0d want 1 20 0", n_wr - w0, last_wr_addr, mask_bad); end
        checks++; if (wr_beats[0] !== 64'h00000104_00000100) begin errors++; $display("[TB] FAIL conflict_beat0: got %h want 0000010400000100", wr_beats[0]); end
        checks++; if (wr_beats[1] !== 64'h0000010C_0000CCDD) begin errors++; $display("[TB] FAIL conflict_beat1: got %h want 0000010c0000ccdd", wr_beats[1]); end
        checks++; if (n_rd - r0 != 1 || last_rd_addr !== 8'h60) begin errors++; $display("[TB] FAIL conflict_refill: got rd %0d addr %h want 1 60", n_rd - r0, last_rd_addr); end
    endtask

    task automatic test_busy_hold;
        logic [31:0] expected; bit hit, wb, to, busy_low, early; int cyc;
        early = 0;
        model_access(32'h500, 4'h0, 32'h0, expected, hit, wb);
        br_busy = 1'b1;
        issue(32'h500, 4'h0, 32'h0);
        repeat (5) begin
            if (br_cmd_en !== 1'b0) early = 1;
            tick;
        end
        br_busy = 1'b0;
        if (br_cmd_en !== 1'b0) early = 1;
        checks++; if (early) begin errors++; $display("[TB] FAIL busy_hold_early: got br_cmd_en 1 while br_busy=1 want 0"); end
        tick;
        checks++; if (br_cmd_en !== 1'b1 || br_cmd !== 1'b0 || br_addr !== 8'hA0) begin errors++; $display("[TB] FAIL busy_hold_issue: got en %b cmd %b addr %h want 1 0 a0", br_cmd_en, br_cmd, br_addr); end
        wait_ready(cyc, to, busy_low);
        checks++; if (to || data_out !== expected) begin errors++; $display("[TB] FAIL busy_hold_data: got %h want %h", data_out, expected); end
    endtask

    task automatic test_reset_mid_fill;
        logic [31:0] expected; bit hit, wb, to, busy_low, found; int cyc, r0;
        found = 0;
        issue(32'h700, 4'h0, 32'h0);
        for (int i = 0; i < 50 && !found; i++) begin
            if (br_rd_data_valid === 1'b1 && cur_beat == 2) found = 1;
            else tick;
        end
        checks++; if (!found) begin errors++; $display("[TB] FAIL midfill_beat2: got no beat 2 want beat 2 within 50 cycles"); end
        rst = 1'b1;
        tick;
        checks++; if (busy !== 1'b0 || br_cmd_en !== 1'b0 || data_ready !== 1'b0) begin errors++; $display("[TB] FAIL midfill_abort: got busy %b en %b ready %b want 0 0 0", busy, br_cmd_en, data_ready); end
        rst = 1'b0;
        for (int l = 0; l < 16; l++) begin m_valid[l] = 0; m_dirty[l] = 0; end
        tick;
        r0 = n_rd;
        model_access(32'h700, 4'h0, 32'h0, expected, hit, wb);
        issue(32'h700, 4'h0, 32'h0);
        wait_ready(cyc, to, busy_low);
        checks++; if (to || cyc == 0 || n_rd - r0 != 1) begin errors++; $display("[TB] FAIL midfill_refill: got cycles %0d reads %0d want miss with 1 read", cyc, n_rd - r0); end
        checks++; if (data_out !== expected) begin errors++; $display("[TB] FAIL midfill_data: got %h want %h", data_out, expected); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] expected, din; logic [3:0] we; bit hit, wb; int a, r0, w0;
        r0 = n_rd; w0 = n_wr;
        for (int i = 0; i < 12; i++) begin
            a   = 32'h700 + 4 * $urandom_range(0, 7);
            we  = (i % 2 == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
            din = $urandom;
            model_access(a, we, din, expected, hit, wb);
            checks++; if (!hit) begin errors++; $display("[TB] FAIL b2b_setup_%0d: got miss want hit", i); end
            enable = 1'b1; address = a; write_enable = we; data_in = din;
            tick;
            checks++; if (data_ready !== 1'b1 || data_out !== expected) begin errors++; $display("[TB] FAIL b2b_%0d: got ready %b data %h want 1 %h", i, data_ready, data_out, expected); end
        end
        enable = 1'b0; write_enable = 4'h0;
        tick;
        checks++; if (data_ready !== 1'b0 || n_rd != r0 || n_wr != w0) begin errors++; $display("[TB] FAIL b2b_end: got ready %b rd %0d wr %0d want 0 0 0", data_ready, n_rd - r0, n_wr - w0); end
    endtask

    task automatic test_random;
        logic [31:0] expected, din; logic [3:0] we; bit hit, wb, to, busy_low; int a, cyc, r0, w0;
        for (int i = 0; i < 150; i++) begin
            a   = ($urandom_range(0, 3) << 9) | ($urandom_range(6, 9) << 5) | ($urandom_range(0, 7) << 2);
            we  = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            din = $urandom;
            r0 = n_rd; w0 = n_wr;
            model_access(a, we, din, expected, hit, wb);
            issue(a, we, din);
            wait_ready(cyc, to, busy_low);
            checks++; if (to) begin errors++; $display("[TB] FAIL rand_timeout_%0d: got no data_ready want ready", i); break; end
            checks++; if (data_out !== expected) begin errors++; $display("[TB] FAIL rand_data_%0d: addr %h got %h want %h", i, a, data_out, expected); end
            checks++; if ((cyc == 0) != hit || n_rd - r0 != (hit ? 0 : 1)) begin errors++; $display("[TB] FAIL rand_hit_%0d: got cycles %0d reads %0d want hit %0d", i, cyc, n_rd - r0, hit); end
            checks++; if (n_wr - w0 != (wb ? 1 : 0)) begin errors++; $display("[TB] FAIL rand_wb_%0d: got %0d writebacks want %0d", i, n_wr - w0, wb); end
            repeat ($urandom_range(0, 1)) tick;
        end
    endtask

    initial begin
        test_reset;
        test_cold_read;
        test_hits;
        test_conflict_wb;
        test_busy_hold;
        test_reset_mid_fill;
        test_back_to_back;
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/dcache_wb.md
Name: dcache_wb

Overview:
- Direct-mapped, write-back data cache for the RISC-V core's load/store port. Successor to the instruction cache.
- Adds byte-masked writes, per-line dirty tracking and eviction write-back bursts.
- Sits between the core's memory stage and BurstRAM. Uses the same br_* wiring and burst geometry as the instruction cache, so both can share one RAM through an arbiter.

Parameters:
- ADDRESS_BITWIDTH, 32, byte address width.
- DATA_BITWIDTH, 32, core word width; divisible by 8.
- LINE_IX_BITWIDTH, 4, 2^4 = 16 lines.
- DATA_IX_IN_LINE_BITWIDTH, 3, 8 words per line.
- RAM_BURST_DATA_COUNT, 4, RAM beats per burst.
- RAM_BURST_DATA_BITWIDTH, 64, bits per beat.
- RAM_DEPTH_BITWIDTH, 4, width of br_addr.
- Constraint: RAM_BURST_DATA_COUNT*RAM_BURST_DATA_BITWIDTH == 2^DATA_IX_IN_LINE_BITWIDTH*DATA_BITWIDTH, i.e. one burst is one line. RAM_BURST_DATA_BITWIDTH is a multiple of DATA_BITWIDTH.

Ports:
- clk  in  1  clock; one clock domain.
- rst  in  1  reset; synchronous, active-high.
- enable  in  1  request strobe; sampled only while busy=0.
- address  in  ADDRESS_BITWIDTH  byte address, word aligned (low 2 bits 0).
- write_enable  in  DATA_BITWIDTH/8  byte write mask; all-zero means read.
- data_in  in  DATA_BITWIDTH  store data.
- data_out  out  DATA_BITWIDTH  load result.
- data_ready  out  1  one-cycle pulse: request completed.
- busy  out  1  high while a miss is being serviced.
- br_cmd  out  1  0 = read, 1 = write.
- br_cmd_en  out  1  one-cycle command strobe.
- br_addr  out  RAM_DEPTH_BITWIDTH  burst address, in RAM beats.
- br_wr_data  out  RAM_BURST_DATA_BITWIDTH  write beat.
- br_data_mask  out  RAM_BURST_DATA_BITWIDTH/8  1 = byte suppressed.
- br_rd_data  in  RAM_BURST_DATA_BITWIDTH  read beat.
- br_rd_data_valid  in  1  read beat valid.
- br_busy  in  1  RAM cannot accept a command.

Behaviour:
- Address split, high to low: tag | line_ix | data_ix | 00.
- Per-line storage: valid, dirty, tag, and 2^DATA_IX_IN_LINE_BITWIDTH words.
- Reset: state IDLE; all valid and dirty bits 0; data_out=0; data_ready=0; busy=0; br_cmd=0; br_cmd_en=0; br_addr=0; br_wr_data=0; br_data_mask=0; burst counters 0. Reset mid-burst aborts the burst immediately; the RAM side is not drained.
- data_ready is a single-cycle pulse and is 0 in every other cycle.
- IDLE, enable=1, hit (valid && tag match):
  - Read: data_out <= word; data_ready=1 next cycle. busy stays 0.
  - Write: merge data_in bytes where the write_enable bit is 1; set dirty; data_out <= merged word; data_ready=1 next cycle.
  - Back-to-back hits every cycle are allowed.
- IDLE, enable=1, miss: latch address, write_enable and data_in; busy <= 1.
  - Victim valid && dirty -> WB_ISSUE.
  - Otherwise -> RD_ISSUE.
- WB_ISSUE: wait while br_busy=1. Then in one cycle: br_cmd=1, br_cmd_en=1, br_data_mask=0, br_addr = victim {tag,line_ix} line base in RAM beats (truncated to RAM_DEPTH_BITWIDTH), br_wr_data = beat 0 (lowest words of the line, word i in bits [(i+1)*DATA_BITWIDTH-1 -: DATA_BITWIDTH]). Go to WB_BEATS.
- WB_BEATS: br_cmd_en=0; drive beats 1..RAM_BURST_DATA_COUNT-1 on consecutive cycles; clear dirty; go to RD_ISSUE.
- RD_ISSUE: wait while br_busy=1. Then br_cmd=0, br_cmd_en=1 for one cycle, br_addr = requested line base; set the new tag; set valid=0 until fill completes. Go to RD_WAIT.
- RD_WAIT / RD_DATA:
  - Each br_rd_data_valid beat writes DATA_PER_RAM_DATA words at burst_data_ix and advances the index.
  - Beats are consecutive once started.
  - After the last beat: valid=1, go to COMPLETE.
- COMPLETE: perform the latched read or write exactly as a hit, with data_ready=1 in the same cycle as busy<=0. Return to IDLE. No early data_ready during the fill.
- enable while busy=1 is ignored.
- Miss latency with no write-back and br_busy=0: 1 (issue) + RAM read latency + RAM_BURST_DATA_COUNT beats + 1.
- A write miss allocates the line (write-allocate); the line is dirty after COMPLETE.
- Internal 64-bit counters: hits, misses, writebacks. Cleared on reset; not ported.

Test Plan:
- Cold read 0x0000_0104, RAM line 0x100 holds words 0x100..0x11C = their addresses -> one read burst with br_addr=0x20, 4 beats; data_out=0x0000_0104, single data_ready pulse, busy 1->0.
- Read 0x108 next cycle -> hit: data_ready after 1 cycle, data_out=0x0000_0108, no br_cmd_en.
- Write 0x108, data_in=0xAABBCCDD, write_enable=4'b0011 -> hit, no RAM traffic; re-read returns 0x0000_CCDD.
- Read conflicting 0x0000_0308 (same line_ix, different tag) -> write burst br_cmd=1, br_addr=0x20, beat 1 = {0x0000_010C, 0x0000_CCDD}; then read burst br_addr=0x60; data_out = RAM[0x308].
- Hold br_busy=1 for 5 cycles at miss -> br_cmd_en stays 0 until the cycle after br_busy falls; result unchanged.
- Assert rst during beat 2 of a fill -> busy=0, br_cmd_en=0 next cycle; subsequent read of the same address misses and refills.
